// File: rtl/iir_sample_decimator.sv
// Boxcar decimator for the IIR filter output stream. It averages blocks of 2^shift
// samples taken at clk/div and queues the results in a 2-entry valid/ready FIFO.
module iir_sample_decimator #(
    parameter int DATA_WIDTH = 16,
    parameter int COUNT_BITS = 10,
    parameter int MAX_SHIFT  = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [COUNT_BITS-1:0]        div,
    input  logic [2:0]                   shift,
    input  logic signed [DATA_WIDTH-1:0] in,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         overrun,
    input  logic                         clr_overrun
);

    localparam int ACC_W = DATA_WIDTH + MAX_SHIFT;

    typedef enum logic {IDLE_BLOCK, ACCUM} block_phase_e;

    logic [COUNT_BITS-1:0]   count_q, count_d;
    logic [MAX_SHIFT-1:0]    n_q, n_d;
    logic [2:0]              eff_q, eff_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [DATA_WIDTH-1:0]   mem_q [2];
    logic [DATA_WIDTH-1:0]   mem_d [2];
    logic                    wr_q, wr_d, rd_q, rd_d;
    logic [1:0]              cnt_q, cnt_d;
    logic                    overrun_q, overrun_d;

    block_phase_e            phase;
    logic                    stb, push, pop, push_ok, drop;
    logic [2:0]              shift_sat, eff_cur;
    logic [MAX_SHIFT-1:0]    last_n;
    logic signed [ACC_W-1:0] sum;
    logic [DATA_WIDTH-1:0]   result;

    assign stb       = (div != '0) && (count_q == div - COUNT_BITS'(1));
    assign phase     = (n_q == '0) ? IDLE_BLOCK : ACCUM;
    assign shift_sat = (shift > 3'(MAX_SHIFT)) ? 3'(MAX_SHIFT) : shift;
    // The decimation factor is captured at the first sample of a block and held.
    assign eff_cur   = (phase == IDLE_BLOCK) ? shift_sat : eff_q;
    assign last_n    = MAX_SHIFT'((32'd1 << eff_cur) - 32'd1);
    assign sum       = acc_q + ACC_W'(in);
    assign result    = DATA_WIDTH'(sum >>> eff_cur);
    assign push      = stb && (n_q == last_n);
    assign pop       = out_valid && out_ready;
    assign push_ok   = push && ((cnt_q != 2'd2) || pop);
    assign drop      = push && (cnt_q == 2'd2) && !pop;

    assign out_data  = mem_q[rd_q];
    assign out_valid = (cnt_q != 2'd0);
    assign overrun   = overrun_q;

    always_comb begin
        count_d   = count_q;
        n_d       = n_q;
        eff_d     = eff_q;
        acc_d     = acc_q;
        mem_d     = mem_q;
        wr_d      = wr_q;
        rd_d      = rd_q;
        cnt_d     = cnt_q;
        overrun_d = overrun_q;

        count_d = ((div == '0) || stb) ? '0 : count_q + COUNT_BITS'(1);

        if (stb) begin
            if (phase == IDLE_BLOCK) begin
                eff_d = shift_sat;
            end
            if (push) begin
                acc_d = '0;
                n_d   = '0;
            end else begin
                acc_d = sum;
                n_d   = n_q + MAX_SHIFT'(1);
            end
        end

        // When full, a simultaneous pop frees the head slot that wr points at.
        if (pop) begin
            rd_d = ~rd_q;
        end
        if (push_ok) begin
            mem_d[wr_q] = result;
            wr_d        = ~wr_q;
        end
        case ({push_ok, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase

        if (drop) begin
            overrun_d = 1'b1;
        end else if (clr_overrun) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q   <= '0;
            n_q       <= '0;
            eff_q     <= '0;
            acc_q     <= '0;
            mem_q[0]  <= '0;
            mem_q[1]  <= '0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            cnt_q     <= 2'd0;
            overrun_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            n_q       <= n_d;
            eff_q     <= eff_d;
            acc_q     <= acc_d;
            mem_q     <= mem_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            cnt_q     <= cnt_d;
            overrun_q <= overrun_d;
        end
    end

endmodule

// File: tb/tb_iir_sample_decimator.sv
// Self-checking bench for iir_sample_decimator: directed vector table, hand sequences
// for multi-cycle corners, and random traffic against a block/queue reference model.
module tb_iir_sample_decimator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  div;
    logic [2:0]  shift;
    logic [15:0] din;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        overrun;
    logic        clr;

    always #5 clk = ~clk;

    iir_sample_decimator #(.DATA_WIDTH(16), .COUNT_BITS(10), .MAX_SHIFT(4)) dut (
        .clk         (clk),
        .reset       (rst_n),
        .div         (div),
        .shift       (shift),
        .in          (din),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .overrun     (overrun),
        .clr_overrun (clr)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: samples of the current block, output queue, sticky flag.
    int          m_cnt = 0;
    int          m_eff = 0;
    int          blk[$];
    logic [15:0] exp_q[$];
    logic        m_ovr = 1'b0;

    task automatic model_step();
        bit stb, pop, push, drop;
        int sum, d, q;
        logic [15:0] res;
        if (!rst_n) begin
            m_cnt = 0;
            blk.delete();
            exp_q.delete();
            m_ovr = 1'b0;
            return;
        end
        pop   = (exp_q.size() > 0) && out_ready;
        stb   = (div != 0) && (m_cnt == int'(div) - 1);
        m_cnt = ((div == 0) || stb) ? 0 : m_cnt + 1;
        push  = 1'b0;
        res   = '0;
        if (stb) begin
            if (blk.size() == 0) m_eff = (shift > 3'd4) ? 4 : int'(shift);
            blk.push_back(int'($signed(din)));
            if (blk.size() == (1 << m_eff)) begin
                sum = 0;
                foreach (blk[i]) sum += blk[i];
                d = 1 << m_eff;
                q = sum / d;
                if ((sum % d != 0) && (sum < 0)) q = q - 1;
                res  = q[15:0];
                push = 1'b1;
                blk.delete();
            end
        end
        drop = push && (exp_q.size() == 2) && !pop;
        if (pop) void'(exp_q.pop_front());
        if (push && !drop) exp_q.push_back(res);
        if (drop) m_ovr = 1'b1;
        else if (clr) m_ovr = 1'b0;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check("valid", 16'(out_valid), 16'(exp_q.size() > 0));
        check("overrun", 16'(overrun), 16'(m_ovr));
        if (exp_q.size() > 0) check("data", out_data, exp_q[0]);
        if (!rst_n) check("rst_data", out_data, 16'h0000);
    endtask

    task automatic drive(input logic r, input logic [9:0] dv, input logic [2:0] sh,
                         input logic [15:0] x, input logic rdy, input logic c);
        rst_n = r; div = dv; shift = sh; din = x; out_ready = rdy; clr = c;
        cycle();
    endtask

    typedef struct {
        logic        rst_n;
        logic [9:0]  div;
        logic [2:0]  shift;
        logic [15:0] din;
        logic        ready;
        logic        clr;
        logic        exp_valid;
        logic [15:0] exp_data;
        logic        exp_ovr;
    } vec_t;

    vec_t vecs[$];

    function automatic void v(logic r, logic [9:0] dv, logic [2:0] sh, logic [15:0] x,
                              logic rdy, logic c, logic ev, logic [15:0] ed, logic eo);
        vec_t t;
        t = '{r, dv, sh, x, rdy, c, ev, ed, eo};
        vecs.push_back(t);
    endfunction

    initial begin
        rst_n = 1'b0; div = '0; shift = '0; din = '0; out_ready = 1'b0; clr = 1'b0;

        // Pass-through at div=4: first output 1 clk after the stb cycle, one per 4 clks.
        repeat (3) v(0, 4, 0, 16'h1234, 1, 0, 0, 16'h0000, 0);
        v(1, 4, 0, 16'h1234, 1, 0, 0, 0, 0);
        v(1, 4, 0, 16'h1234, 1, 0, 0, 0, 0);
        v(1, 4, 0, 16'h1234, 1, 0, 0, 0, 0);
        v(1, 4, 0, 16'h1234, 1, 0, 1, 16'h1234, 0);
        v(1, 4, 0, 16'h1234, 1, 0, 0, 0, 0);
        v(1, 4, 0, 16'h1234, 1, 0, 0, 0, 0);
        v(1, 4, 0, 16'h1234, 1, 0, 0, 0, 0);
        v(1, 4, 0, 16'h1234, 1, 0, 1, 16'h1234, 0);
        // Average of four: (10+20+30+41)>>>2 = 25.
        v(0, 1, 2, 0, 1, 0, 0, 16'h0000, 0);
        v(1, 1, 2, 10, 1, 0, 0, 0, 0);
        v(1, 1, 2, 20, 1, 0, 0, 0, 0);
        v(1, 1, 2, 30, 1, 0, 0, 0, 0);
        v(1, 1, 2, 41, 1, 0, 1, 16'd25, 0);
        v(1, 1, 2, 0, 1, 0, 0, 0, 0);
        // Floor rounding of negatives and no wrap at full scale.
        v(0, 1, 1, 0, 1, 0, 0, 16'h0000, 0);
        v(1, 1, 1, 16'hFFFD, 1, 0, 0, 0, 0);
        v(1, 1, 1, 16'hFFFE, 1, 0, 1, 16'hFFFD, 0);
        v(1, 1, 1, 16'h7FFF, 1, 0, 0, 0, 0);
        v(1, 1, 1, 16'h7FFF, 1, 0, 1, 16'h7FFF, 0);
        // Back-pressure: full FIFO drops, set beats clear, drain in order, then clear.
        v(0, 1, 0, 0, 0, 0, 0, 16'h0000, 0);
        v(1, 1, 0, 1, 0, 0, 1, 1, 0);
        v(1, 1, 0, 2, 0, 0, 1, 1, 0);
        v(1, 1, 0, 3, 0, 0, 1, 1, 1);
        v(1, 1, 0, 4, 0, 1, 1, 1, 1);
        v(1, 0, 0, 0, 1, 0, 1, 2, 1);
        v(1, 0, 0, 0, 1, 0, 0, 0, 1);
        v(1, 0, 0, 0, 0, 1, 0, 0, 0);
        // Push and pop together while full, then with a single entry.
        v(0, 1, 0, 0, 0, 0, 0, 16'h0000, 0);
        v(1, 1, 0, 5, 0, 0, 1, 5, 0);
        v(1, 1, 0, 6, 0, 0, 1, 5, 0);
        v(1, 1, 0, 7, 1, 0, 1, 6, 0);
        v(1, 0, 0, 0, 1, 0, 1, 7, 0);
        v(1, 0, 0, 0, 1, 0, 0, 0, 0);
        v(1, 1, 0, 8, 1, 0, 1, 8, 0);
        v(1, 1, 0, 9, 1, 0, 1, 9, 0);
        v(1, 0, 0, 0, 1, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].div, vecs[i].shift, vecs[i].din, vecs[i].ready, vecs[i].clr);
            check($sformatf("vec%0d_valid", i), 16'(out_valid), 16'(vecs[i].exp_valid));
            check($sformatf("vec%0d_ovr", i), 16'(overrun), 16'(vecs[i].exp_ovr));
            if (vecs[i].exp_valid || !vecs[i].rst_n)
                check($sformatf("vec%0d_data", i), out_data, vecs[i].exp_data);
        end

        // shift=7 saturates to 16-sample blocks: 100*(0+..+15)/16 = 750.
        drive(0, 1, 7, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            drive(1, 1, 7, 16'(i * 100), 0, 0);
            if (i == 14) check("sat_not_early", 16'(out_valid), 16'd0);
        end
        check("sat_valid", 16'(out_valid), 16'd1);
        check("sat_data", out_data, 16'd750);
        drive(1, 0, 7, 0, 1, 0);

        // Shift change mid-block is ignored: (4+8+12+17)>>>2 = 10, next block passes through.
        drive(1, 1, 2, 4, 1, 0);
        drive(1, 1, 2, 8, 1, 0);
        drive(1, 1, 0, 12, 1, 0);
        check("midshift_pending", 16'(out_valid), 16'd0);
        drive(1, 1, 0, 17, 1, 0);
        check("midshift_data", out_data, 16'd10);
        drive(1, 1, 0, 33, 1, 0);
        check("next_block_data", out_data, 16'd33);
        drive(1, 0, 0, 0, 1, 0);

        // div=0 never strobes; reset mid-block discards the partial sum.
        drive(0, 0, 2, 0, 1, 0);
        repeat (100) drive(1, 0, 2, 16'($urandom), 1, 0);
        check("div0_valid", 16'(out_valid), 16'd0);
        drive(1, 1, 2, 100, 1, 0);
        drive(1, 1, 2, 100, 1, 0);
        drive(0, 1, 2, 100, 1, 0);
        for (int i = 0; i < 4; i++) drive(1, 1, 2, 8, 1, 0);
        check("post_reset_valid", 16'(out_valid), 16'd1);
        check("post_reset_data", out_data, 16'd8);

        // Random traffic with varied divider and back-pressure.
        for (int seg = 0; seg < 6; seg++) begin
            logic [9:0] dsel;
            case (seg)
                0: dsel = 1;
                1: dsel = 1;
                2: dsel = 2;
                3: dsel = 3;
                4: dsel = 5;
                default: dsel = 0;
            endcase
            drive(0, dsel, 0, 0, 0, 0);
            repeat (300) begin
                drive(1, dsel, 3'($urandom_range(0, 7)), 16'($urandom),
                      (seg % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                      $urandom_range(0, 15) == 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
